masku_cmp_sequencer: RTL and testbench
======================================

Name: masku_cmp_sequencer

Overview:
- Controls the ALU/FPU result-compression path of the mask unit for mask-producing compares (VMFEQ..VMSBC).
- Accepts one instruction at a time, handshakes result beats from all lanes, and drives the bit write pointer used to pack compressed results.
- Emits a commit request to the VRF writeback whenever the NrLanes*ELEN-bit mask word is full or the last element has been processed.
- Sits between the masku issue logic and the operand-unpacking block, and owns the vrf_pnt register.

Parameters:
- NrLanes, 4, number of lanes; power of two, 1..16.
- VlWidth, 16, bit width of vl.
- DataWidth (localparam), NrLanes*ELEN, mask-word width in bits.
- PntWidth (localparam), idx_width(DataWidth)+1, pointer width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_valid_i  in  1  new instruction available
- start_ready_o  out  1  sequencer idle, accepts instruction
- start_vl_i  in  VlWidth  element count
- start_eew_i  in  2  vew_e of source operand (eew_vs2)
- alu_valid_i  in  NrLanes  per-lane result valid
- alu_ready_o  out  NrLanes  per-lane result ready
- vrf_pnt_o  out  PntWidth  bit offset of the current beat inside the mask word
- commit_valid_o  out  1  mask word ready for writeback
- commit_ready_i  in  1  writeback accepts the word
- commit_last_o  out  1  word is the last of the instruction
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the instruction completes

Behaviour:
- Reset values: state IDLE, vrf_pnt_o 0, remaining 0, commit_valid_o 0, commit_last_o 0, done_o 0, alu_ready_o 0. Reset mid-operation discards all progress.
- FSM states: IDLE, ACCUM, COMMIT.
- IDLE:
  - start_ready_o=1.
  - On start_valid_i, latch vl and eew and clear vrf_pnt.
  - vl==0: go IDLE and pulse done_o next cycle; no commit is issued.
  - Otherwise go to ACCUM.
- ACCUM:
  - epb = (NrLanes*8)>>eew elements per beat; n = min(epb, remaining).
  - A beat fires when &alu_valid_i. alu_ready_o = {NrLanes{&alu_valid_i}} in ACCUM and 0 otherwise, so all lanes consume in lockstep; partial valid is never acknowledged.
  - vrf_pnt_o shows the pre-beat offset during the firing cycle (combinationally usable for packing).
  - On fire: remaining -= n.
  - If vrf_pnt+n == DataWidth, or remaining becomes 0: vrf_pnt <= 0, commit_valid_o <= 1, commit_last_o <= (remaining becomes 0), go to COMMIT.
  - Else vrf_pnt += n.
- COMMIT:
  - No beats accepted.
  - Hold commit_valid_o/last until commit_ready_i.
  - On handshake, clear both. If last, go IDLE and pulse done_o the same cycle as the handshake; else go to ACCUM.
- Timing: one beat per cycle at most. The commit handshake costs at least 1 bubble cycle per word.
- Arithmetic:
  - vrf_pnt never exceeds DataWidth-1 when observed.
  - n*... sums computed at PntWidth+1 bits; no wrap.
- Simultaneous events: start_valid_i outside IDLE is ignored (start_ready_o=0). Commit handshake and a new start cannot coincide; start is accepted the cycle after done_o.

Optional Feature:
- Macro: MASKU_CMP_SEQ_PERF_EN.
- When defined:
  - Adds outputs stall_cnt_o[31:0], counting ACCUM cycles with !&alu_valid_i.
  - Adds outputs bp_cnt_o[31:0], counting COMMIT cycles with !commit_ready_i.
  - Both are saturating, cleared on reset and on instruction start.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Add to ara_pkg: typedef masku_seq_state_e {IDLE, ACCUM, COMMIT}.
- The epb computation goes in a package function masku_elems_per_beat(NrLanes, vew_e).
- Reuse vew_e, ELEN and ELENB from rvv_pkg/ara_pkg.
- No sub-module; single FSM plus counters.

Test Plan:
All scenarios use NrLanes=4, so DataWidth=256.
- eew=EW64 (epb=4), vl=300, always valid, commit_ready=1:
  - 64 beats, then commit (last=0) with vrf_pnt back to 0.
  - 11 beats with vrf_pnt 0..40 step 4, then commit last=1.
  - done_o exactly once.
- eew=EW8 (epb=32), vl=100:
  - Beats at vrf_pnt 0,32,64,96 (n=32,32,32,4).
  - Single commit last=1 after beat 4.
- vl=0: start accepted; done_o pulses next cycle; commit_valid_o never rises; alu_ready_o stays 0.
- Lane skew, eew=EW32, vl=16: lane 2 valid delayed 3 cycles → alu_ready_o=0 on all lanes until all valid; vrf_pnt frozen.
- Backpressure: commit_ready_i=0 for 5 cycles at the first commit → commit_valid_o held; alu_ready_o=0; no vrf_pnt change. Resumes after handshake.
- Reset asserted mid-ACCUM (vrf_pnt=128) → all outputs return to reset values asynchronously; the next start runs from vrf_pnt 0.

Source files
------------

// File: rtl/masku_cmp_sequencer_pkg.sv
// Shared types and helpers for the mask-unit compare result sequencer.
// Optional counters in the top are enabled by MASKU_CMP_SEQ_PERF_EN.
package masku_cmp_sequencer_pkg;

    localparam int unsigned ELEN  = 64;
    localparam int unsigned ELENB = ELEN / 8;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMMIT
    } masku_seq_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One mask bit per element; each lane delivers ELENB elements at EW8.
    function automatic int unsigned masku_elems_per_beat(
        int unsigned nr_lanes,
        vew_e        eew
    );
        return (nr_lanes * ELENB) >> eew;
    endfunction

endpackage

// File: rtl/masku_cmp_sequencer_if.sv
// Handshake bundle between masku issue/lanes/writeback and the sequencer.
// slave = sequencer side, master = surrounding logic.
interface masku_cmp_sequencer_if #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VlWidth = 16
) ();
    import masku_cmp_sequencer_pkg::*;

    localparam int unsigned PntWidth = idx_width(NrLanes * ELEN) + 1;

    logic                start_valid_i;
    logic                start_ready_o;
    logic [VlWidth-1:0]  start_vl_i;
    vew_e                start_eew_i;
    logic [NrLanes-1:0]  alu_valid_i;
    logic [NrLanes-1:0]  alu_ready_o;
    logic [PntWidth-1:0] vrf_pnt_o;
    logic                commit_valid_o;
    logic                commit_ready_i;
    logic                commit_last_o;
    logic                busy_o;
    logic                done_o;

    modport slave (
        input  start_valid_i, start_vl_i, start_eew_i,
        input  alu_valid_i, commit_ready_i,
        output start_ready_o, alu_ready_o, vrf_pnt_o,
        output commit_valid_o, commit_last_o, busy_o, done_o
    );

    modport master (
        output start_valid_i, start_vl_i, start_eew_i,
        output alu_valid_i, commit_ready_i,
        input  start_ready_o, alu_ready_o, vrf_pnt_o,
        input  commit_valid_o, commit_last_o, busy_o, done_o
    );

endinterface

// File: rtl/masku_cmp_sequencer.sv
// Compare-result compression sequencer: owns vrf_pnt and mask-word commits.
// MASKU_CMP_SEQ_PERF_EN adds saturating stall/backpressure counters.
module masku_cmp_sequencer
    import masku_cmp_sequencer_pkg::*;
#(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VlWidth = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    masku_cmp_sequencer_if.slave seq
`ifdef MASKU_CMP_SEQ_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] bp_cnt_o
`endif
);

    localparam int unsigned DataWidth = NrLanes * ELEN;
    localparam int unsigned PntWidth  = idx_width(DataWidth) + 1;
    localparam int unsigned SumWidth  = PntWidth + 1;
    localparam int unsigned CmpWidth  =
        (VlWidth > SumWidth) ? VlWidth : SumWidth;

    masku_seq_state_e     state_q, state_d;
    logic [PntWidth-1:0]  pnt_q, pnt_d;
    logic [VlWidth-1:0]   rem_q, rem_d;
    vew_e                 eew_q, eew_d;
    logic                 cval_q, cval_d;
    logic                 clast_q, clast_d;
    logic                 done_q, done_d;

    logic                 all_valid;
    logic                 commit_hs;
    logic [CmpWidth-1:0]  epb_w, rem_w, n_w;
    logic [SumWidth-1:0]  sum;
    logic [VlWidth-1:0]   rem_next;

    assign all_valid = &seq.alu_valid_i;
    assign epb_w     = CmpWidth'(masku_elems_per_beat(NrLanes, eew_q));
    assign rem_w     = CmpWidth'(rem_q);
    assign n_w       = (rem_w < epb_w) ? rem_w : epb_w;
    assign sum       = SumWidth'(pnt_q) + SumWidth'(n_w);
    assign rem_next  = rem_q - VlWidth'(n_w);

    always_comb begin
        state_d   = state_q;
        pnt_d     = pnt_q;
        rem_d     = rem_q;
        eew_d     = eew_q;
        cval_d    = cval_q;
        clast_d   = clast_q;
        done_d    = 1'b0;
        commit_hs = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (seq.start_valid_i) begin
                    eew_d = seq.start_eew_i;
                    rem_d = seq.start_vl_i;
                    pnt_d = '0;
                    if (seq.start_vl_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (all_valid) begin
                    rem_d = rem_next;
                    if (sum == SumWidth'(DataWidth) || rem_next == '0) begin
                        pnt_d   = '0;
                        cval_d  = 1'b1;
                        clast_d = (rem_next == '0);
                        state_d = COMMIT;
                    end else begin
                        pnt_d = PntWidth'(sum);
                    end
                end
            end
            COMMIT: begin
                if (cval_q && seq.commit_ready_i) begin
                    commit_hs = 1'b1;
                    cval_d    = 1'b0;
                    clast_d   = 1'b0;
                    state_d   = clast_q ? IDLE : ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pnt_q   <= '0;
            rem_q   <= '0;
            eew_q   <= EW8;
            cval_q  <= 1'b0;
            clast_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pnt_q   <= pnt_d;
            rem_q   <= rem_d;
            eew_q   <= eew_d;
            cval_q  <= cval_d;
            clast_q <= clast_d;
            done_q  <= done_d;
        end
    end

    assign seq.start_ready_o  = (state_q == IDLE);
    assign seq.alu_ready_o    =
        {NrLanes{all_valid && (state_q == ACCUM)}};
    assign seq.vrf_pnt_o      = pnt_q;
    assign seq.commit_valid_o = cval_q;
    assign seq.commit_last_o  = clast_q;
    assign seq.busy_o         = (state_q != IDLE);
    // vl==0 completes from a register; the last commit completes on handshake.
    assign seq.done_o         = done_q | (commit_hs & clast_q);

`ifdef MASKU_CMP_SEQ_PERF_EN
    logic        start_acc;
    logic [31:0] stall_q, bp_q;

    assign start_acc = (state_q == IDLE) && seq.start_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            bp_q    <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            if (state_q == ACCUM && !all_valid && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (state_q == COMMIT && !seq.commit_ready_i && bp_q != '1) begin
                bp_q <= bp_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign bp_cnt_o    = bp_q;
`endif

endmodule

// File: tb/tb_masku_cmp_sequencer.sv
// Randomized bench for masku_cmp_sequencer against a queue-based model.
// Optional MASKU_CMP_SEQ_PERF_EN ports are connected when defined.
module tb_masku_cmp_sequencer;
    import masku_cmp_sequencer_pkg::*;

    localparam int NL = 4;
    localparam int VW = 16;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masku_cmp_sequencer_if #(.NrLanes(NL), .VlWidth(VW)) sif ();

`ifdef MASKU_CMP_SEQ_PERF_EN
    logic [31:0] stall_cnt, bp_cnt;
`endif

    masku_cmp_sequencer #(.NrLanes(NL), .VlWidth(VW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .seq    (sif.slave)
`ifdef MASKU_CMP_SEQ_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .bp_cnt_o    (bp_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    int exp_beats[$];
    bit exp_commits[$];
    int beats_seen = 0;
    int done_cnt = 0;

    function automatic void chk(bit ok, string name, longint act, longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // Per-cycle compare against the model queues
    always @(negedge clk) begin
        logic allv;
        bit   lst;
        if (rst_n) begin
            allv = &sif.alu_valid_i;
            chk(sif.vrf_pnt_o < DW, "pnt_range", sif.vrf_pnt_o, DW - 1);
            if (sif.alu_ready_o != '0) begin
                chk(sif.alu_ready_o == '1 && allv && !sif.commit_valid_o,
                    "beat_ready", sif.alu_ready_o, 15);
                if (exp_beats.size() == 0) begin
                    chk(1'b0, "beat_unexpected", sif.vrf_pnt_o, -1);
                end else begin
                    chk(sif.vrf_pnt_o == exp_beats[0], "beat_pnt",
                        sif.vrf_pnt_o, exp_beats[0]);
                    void'(exp_beats.pop_front());
                end
                beats_seen++;
            end else if (sif.busy_o && !sif.commit_valid_o && allv) begin
                chk(1'b0, "beat_stalled", 0, 15);
            end
            if (sif.commit_valid_o && exp_commits.size() == 0) begin
                chk(1'b0, "commit_unexpected", 1, 0);
            end
            if (sif.commit_valid_o && sif.commit_ready_i
                && exp_commits.size() != 0) begin
                lst = exp_commits.pop_front();
                chk(exp_beats.size() == 0 || !lst, "commit_early",
                    exp_beats.size(), 0);
                chk(sif.commit_last_o == lst, "commit_last",
                    sif.commit_last_o, lst);
                chk(sif.done_o == lst, "done_on_commit", sif.done_o, lst);
            end
            if (sif.done_o) begin
                done_cnt++;
                chk(exp_beats.size() == 0 && exp_commits.size() == 0,
                    "done_early", exp_beats.size() + exp_commits.size(), 0);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk(sif.vrf_pnt_o == 0, {tag, "_pnt"}, sif.vrf_pnt_o, 0);
        chk(sif.commit_valid_o == 0, {tag, "_cval"}, sif.commit_valid_o, 0);
        chk(sif.commit_last_o == 0, {tag, "_clast"}, sif.commit_last_o, 0);
        chk(sif.done_o == 0, {tag, "_done"}, sif.done_o, 0);
        chk(sif.alu_ready_o == 0, {tag, "_ready"}, sif.alu_ready_o, 0);
        chk(sif.busy_o == 0, {tag, "_busy"}, sif.busy_o, 0);
        chk(sif.start_ready_o == 1, {tag, "_sready"}, sif.start_ready_o, 1);
    endtask

    task automatic run_instr(int vl, int eew, int vpct, int rpct,
                             bit skew, bit bp, int rst_at,
                             int exp_nb, int exp_nc, int exp_lastpnt);
        int  epb, rem, pnt, n, nb, d0, b0, bp_left;
        bit  ok, bp_chk;
        epb = (NL * 8) >> eew;
        rem = vl;
        pnt = 0;
        exp_beats.delete();
        exp_commits.delete();
        while (rem > 0) begin
            n = (rem < epb) ? rem : epb;
            exp_beats.push_back(pnt);
            rem -= n;
            pnt += n;
            if (pnt == DW || rem == 0) begin
                exp_commits.push_back(rem == 0);
                pnt = 0;
            end
        end
        nb = exp_beats.size();
        if (exp_nb >= 0) begin
            chk(nb == exp_nb, "model_beats", nb, exp_nb);
            chk(exp_commits.size() == exp_nc, "model_commits",
                exp_commits.size(), exp_nc);
            if (nb > 0) begin
                chk(exp_beats[nb-1] == exp_lastpnt, "model_lastpnt",
                    exp_beats[nb-1], exp_lastpnt);
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (sif.start_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, "start_ready_timeout", ok, 1);
        if (!ok) return;
        b0 = beats_seen;
        d0 = done_cnt;
        sif.start_valid_i = 1'b1;
        sif.start_vl_i    = VW'(vl);
        sif.start_eew_i   = vew_e'(eew);
        @(posedge clk);
        #1;
        sif.start_valid_i = 1'b0;
        sif.start_vl_i    = VW'($urandom);
        sif.start_eew_i   = vew_e'($urandom_range(3));
        if (vl == 0) begin
            sif.alu_valid_i = '1;
            #1;
            chk(sif.done_o == 1, "vl0_done", sif.done_o, 1);
            chk(sif.commit_valid_o == 0, "vl0_cval", sif.commit_valid_o, 0);
            chk(sif.alu_ready_o == 0, "vl0_ready", sif.alu_ready_o, 0);
        end
        bp_left = bp ? 5 : 0;
        for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
            if (rst_at > 0 && beats_seen - b0 == rst_at) begin
                chk(sif.vrf_pnt_o == 128, "pnt_before_rst",
                    sif.vrf_pnt_o, 128);
                sif.alu_valid_i = '1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                exp_beats.delete();
                exp_commits.delete();
                @(negedge clk);
                rst_n = 1'b1;
                sif.alu_valid_i = '0;
                sif.commit_ready_i = 1'b0;
                return;
            end
            if (skew && i < 3) begin
                sif.alu_valid_i = 4'b1011;
            end else begin
                for (int l = 0; l < NL; l++) begin
                    sif.alu_valid_i[l] = ($urandom_range(99) < vpct);
                end
            end
            bp_chk = 1'b0;
            if (sif.commit_valid_o && bp_left > 0) begin
                sif.commit_ready_i = 1'b0;
                bp_left--;
                bp_chk = 1'b1;
            end else begin
                sif.commit_ready_i = ($urandom_range(99) < rpct);
            end
            @(negedge clk);
            if (skew && i < 3) begin
                chk(sif.alu_ready_o == 0 && sif.vrf_pnt_o == 0, "skew_hold",
                    sif.alu_ready_o, 0);
            end
            if (bp_chk) begin
                chk(sif.commit_valid_o && sif.alu_ready_o == 0
                    && sif.vrf_pnt_o == 0, "bp_hold", sif.commit_valid_o, 1);
            end
            @(posedge clk);
            #1;
        end
        chk(done_cnt != d0, "done_timeout", done_cnt, d0 + 1);
        sif.alu_valid_i    = '0;
        sif.commit_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
        chk(beats_seen - b0 == nb, "beat_count", beats_seen - b0, nb);
    endtask

    initial begin
        int vl, eew;
        sif.start_valid_i  = 1'b0;
        sif.start_vl_i     = '0;
        sif.start_eew_i    = EW8;
        sif.alu_valid_i    = '1;
        sif.commit_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        sif.alu_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(300, 3, 100, 100, 0, 0, 0, 75, 2, 40);
        run_instr(100, 0, 100, 100, 0, 0, 0, 4, 1, 96);
        run_instr(0, 2, 100, 100, 0, 0, 0, 0, 0, 0);
        run_instr(16, 2, 100, 100, 1, 0, 0, 2, 1, 8);
        run_instr(300, 3, 100, 100, 0, 1, 0, 75, 2, 40);
        run_instr(300, 3, 100, 100, 0, 0, 32, -1, 0, 0);
        run_instr(100, 0, 100, 100, 0, 0, 0, 4, 1, 96);

        for (int t = 0; t < 20; t++) begin
            vl  = ($urandom_range(9) == 0) ? 0 : $urandom_range(500, 1);
            eew = $urandom_range(3);
            run_instr(vl, eew, $urandom_range(100, 70),
                      $urandom_range(100, 30), 0, 0, 0, -1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
